// File: rtl/rad4_mult_ctrl.sv
// Sequencing controller for an iterative radix-4 multiplier core: load, DIGITS iterations, capture, hand-off.
// Optional abort input enabled by defining RAD4_MULT_CTRL_ABORT_EN.
module rad4_mult_ctrl #(
    parameter int unsigned DIGITS = 256
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef RAD4_MULT_CTRL_ABORT_EN
    input  logic                  abort,
`endif
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*DIGITS-1:0]   in_x,
    input  logic [2*DIGITS-1:0]   in_y,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_prod,
    output logic                  busy,
    output logic [2*DIGITS-1:0]   mul_x,
    output logic [2*DIGITS-1:0]   mul_y,
    output logic                  mul_reset,
    output logic                  mul_done,
    input  logic [4*DIGITS-1:0]   mul_out
);

    localparam int unsigned OPW   = 2 * DIGITS;
    localparam int unsigned PRW   = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_CAPT = 3'd3,
        S_DONE = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OPW-1:0]   mul_x_q, mul_x_d;
    logic [OPW-1:0]   mul_y_q, mul_y_d;
    logic [PRW-1:0]   prod_q, prod_d;
    logic             out_valid_q, out_valid_d;
    logic             last_iter;
`ifdef RAD4_MULT_CTRL_ABORT_EN
    logic             abort_hit;
`endif

    assign last_iter = (state_q == S_RUN) && (cnt_q == CNT_LAST);

`ifdef RAD4_MULT_CTRL_ABORT_EN
    // Abort only cancels an operation in flight; a finished product is never dropped.
    assign abort_hit = abort && ((state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_CAPT));
`endif

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mul_x_q     <= '0;
            mul_y_q     <= '0;
            prod_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mul_x_q     <= mul_x_d;
            mul_y_q     <= mul_y_d;
            prod_q      <= prod_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mul_x_d     = mul_x_q;
        mul_y_d     = mul_y_q;
        prod_d      = prod_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mul_x_d = in_x;
                    mul_y_d = in_y;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_CAPT;
                end
            end
            S_CAPT: begin
                prod_d      = mul_out;
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
`ifdef RAD4_MULT_CTRL_ABORT_EN
        if (abort_hit) begin
            state_d     = S_IDLE;
            prod_d      = prod_q;
            out_valid_d = 1'b0;
        end
`endif
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign out_prod  = prod_q;
    assign mul_x     = mul_x_q;
    assign mul_y     = mul_y_q;
    assign mul_done  = !reset && last_iter;

    // Core is held cleared through reset and loads operands as LOAD ends.
`ifdef RAD4_MULT_CTRL_ABORT_EN
    assign mul_reset = reset || (state_q == S_LOAD) || abort_hit;
`else
    assign mul_reset = reset || (state_q == S_LOAD);
`endif

endmodule

// File: doc/rad4_mult_ctrl.md
RAD4_MULT_CTRL -- requirements
Module: rad4_mult_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 256: operand width is 2*DIGITS bits, product width is 4*DIGITS bits, DIGITS >= 2.
REQ-002 SHALL have port clk  in  1: clock; all state is updated on the rising edge.
REQ-003 SHALL have port reset  in  1: reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  in  1: the requester presents operands.
REQ-005 SHALL have port in_ready  out  1: the controller accepts operands.
REQ-006 SHALL have ports in_x and in_y  in  2*DIGITS: unsigned multiplicand and multiplier.
REQ-007 SHALL have port out_valid  out  1: the product is available.
REQ-008 SHALL have port out_ready  in  1: the consumer accepts the product.
REQ-009 SHALL have port out_prod  out  4*DIGITS: registered product.
REQ-010 SHALL have port busy  out  1: high in every state except IDLE.
REQ-011 SHALL have ports mul_x and mul_y  out  2*DIGITS: registered operands driven to the multiplier core.
REQ-012 SHALL have port mul_reset  out  1: load/reset strobe to the core.
REQ-013 SHALL have port mul_done  out  1: final-iteration strobe to the core.
REQ-014 SHALL have port mul_out  in  4*DIGITS: the core's registered result.

Function
REQ-015 SHALL implement the FSM states IDLE, LOAD, RUN, CAPT and DONE, with a state-register decode only.
REQ-016 SHALL drive in_ready = 1 only in IDLE; when in_valid && in_ready at an edge, mul_x <= in_x, mul_y <= in_y and the state goes to LOAD.
REQ-017 SHALL drive mul_reset = reset OR (state==LOAD), so the core loads the operands at the edge that ends LOAD; LOAD lasts exactly 1 cycle, then RUN.
REQ-018 SHALL run an iteration counter of width clog2(DIGITS) that clears on entry to RUN and increments each RUN cycle; RUN lasts exactly DIGITS cycles.
REQ-019 SHALL assert mul_done only in the RUN cycle with counter == DIGITS-1; the next state is CAPT.
REQ-020 SHALL, in CAPT (1 cycle), load out_prod <= mul_out at the edge ending CAPT; the next state is DONE.
REQ-021 SHALL, in DONE, hold out_valid = 1 and keep out_prod stable until out_valid && out_ready, then go to IDLE.
REQ-022 SHALL give a latency of exactly DIGITS+2 rising edges from the accepting edge to the edge that sets out_valid.
REQ-023 SHALL leave mul_x and mul_y unchanged from acceptance until the next acceptance.
REQ-024 SHALL not accept a new operation in DONE, even with out_ready and in_valid both high; the earliest next acceptance is the edge after the return to IDLE.
REQ-025 SHALL keep mul_done low outside RUN, including when DIGITS == 2^k and the counter wraps.
REQ-026 SHALL treat in_x and in_y as unsigned; out_prod == in_x * in_y modulo 2^(4*DIGITS).

Reset
REQ-027 SHALL, when reset is high at an edge in any state, set state = IDLE, counter = 0, out_valid = 0, out_prod = 0, mul_x = 0, mul_y = 0 and busy = 0.
REQ-028 SHALL hold mul_reset = 1 and mul_done = 0 throughout reset, so a reset mid-RUN also clears the core.
REQ-029 SHALL drive in_ready = 1 in the first cycle after reset deasserts.

Configuration
REQ-030 SHALL, with macro RAD4_MULT_CTRL_ABORT_EN defined, add port abort  in  1.
REQ-031 SHALL, with the macro defined, move the FSM to IDLE at the next edge when abort is high in LOAD, RUN or CAPT; out_valid stays 0, out_prod is unchanged and mul_reset is driven high during that abort cycle.
REQ-032 SHALL, with the macro defined, ignore abort in IDLE and DONE.
REQ-033 SHALL, without the macro, have no abort port and no abort logic.

Verification (DIGITS=4: 8-bit operands, 16-bit product)
REQ-034 SHALL cover: in_x=8'd13, in_y=8'd11, out_ready=1 -> out_prod=16'h008F, out_valid rises exactly 6 edges after acceptance, mul_done high for exactly 1 cycle.
REQ-035 SHALL cover: in_x=8'hFF, in_y=8'hFF -> out_prod=16'hFE01; in_x=8'h00, in_y=8'hA5 -> out_prod=16'h0000.
REQ-036 SHALL cover: out_ready held low for 10 cycles in DONE -> out_valid stays 1, out_prod stable, in_ready stays 0; product retires on the edge where out_ready rises.
REQ-037 SHALL cover: reset pulsed for 1 cycle at the 2nd RUN cycle -> IDLE, out_valid=0, out_prod=0, mul_reset high that cycle; a subsequent 7*9 yields 16'h003F.
REQ-038 SHALL cover: back-to-back requests with in_valid held high -> second acceptance exactly 1 edge after the first product retires; no operand corruption.
REQ-039 SHALL cover, with RAD4_MULT_CTRL_ABORT_EN: abort in the 3rd RUN cycle -> IDLE next edge, out_valid never asserted, out_prod keeps its previous value.
